// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU. One 1-bit slice is evaluated per clock, LSB
// first, with the carry held in a single register between slices. An
// accepted request takes exactly W RUN cycles followed by a one-cycle DONE.
//
// Ports:
//   clk     sole clock, rising edge
//   rst_n   synchronous active-low reset
//   start   request strobe; operands/opcode captured when accepted (IDLE/DONE)
//   a, b    W-bit operands
//   c_in    carry-in to bit 0
//   ALOP    opcode: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB,
//           110/111 reserved (zero result)
//   busy    high while in RUN
//   done    one-cycle pulse, result valid
//   result  [W-1:0] data, [W] carry (ADD) / borrow (SUB), 0 otherwise
module serial_alu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic [2:0]   ALOP,
  output logic         busy,
  output logic         done,
  output logic [W:0]   result
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [2:0]    r_op;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [W:0]    r_result;

  logic          w_accept;
  logic          w_bb;
  logic          w_sum;
  logic          w_cout;
  logic          w_bit;
  logic          w_flag;

  // A request is taken in IDLE and also in DONE (back-to-back operation).
  assign w_accept = start && (r_state != S_RUN);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  assign result = r_result;

  // One slice of the datapath. Operands are shifted right each RUN cycle so
  // the current bit is always at position 0.
  always_comb begin
    w_bb   = (r_op == OP_SUB) ? ~r_b[0] : r_b[0];
    w_sum  = r_a[0] ^ w_bb ^ r_carry;
    w_cout = (r_a[0] & w_bb) | (r_carry & (r_a[0] ^ w_bb));
    w_bit  = 1'b0;
    w_flag = 1'b0;
    case (r_op)
      OP_AND: w_bit = r_a[0] & r_b[0];
      OP_OR:  w_bit = r_a[0] | r_b[0];
      OP_XOR: w_bit = r_a[0] ^ r_b[0];
      OP_NOR: w_bit = ~(r_a[0] | r_b[0]);
      OP_ADD: begin
        w_bit  = w_sum;
        w_flag = w_cout;
      end
      OP_SUB: begin
        w_bit  = w_sum;
        w_flag = ~w_cout;
      end
      default: begin
        w_bit  = 1'b0;
        w_flag = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= ALOP;
      r_carry <= c_in;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a             <= r_a >> 1;
      r_b             <= r_b >> 1;
      r_carry         <= w_cout;
      r_result[r_cnt] <= w_bit;
      if (r_cnt == LAST) begin
        r_result[W] <= w_flag;
      end
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu at W=8: a table of directed vectors
// plus hand-written sequences for mid-RUN start, back-to-back and reset abort.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [2:0]   ALOP;
  logic         busy;
  logic         done;
  logic [W:0]   result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_alu #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
    .ALOP   (ALOP),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] va;
    logic [7:0] vb;
    logic       ci;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and watch the following 20 cycles.
  task automatic run_vec(input vec_t v);
    int         busy_cnt;
    int         done_cnt;
    int         lat;
    logic [8:0] got;
    @(negedge clk);
    a = v.va; b = v.vb; c_in = v.ci; ALOP = v.op; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Inputs changed after acceptance must not disturb the operation.
    a = 8'($urandom); b = 8'($urandom); c_in = ~v.ci; ALOP = 3'($urandom);
    busy_cnt = 0; done_cnt = 0; lat = -1; got = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = cyc;
        got = result;
      end
    end
    check({v.name, " busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({v.name, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({v.name, " latency"}, 32'(lat), 32'd8);
    check({v.name, " result"}, 32'(got), 32'(v.exp));
    check({v.name, " result_hold"}, 32'(result), 32'(v.exp));
  endtask

  initial begin
    int         done_cnt;
    int         t1;
    int         t2;
    logic [8:0] r1;
    logic [8:0] r2;

    vecs[0]  = '{"add_ff_01",   3'b100, 8'hFF, 8'h01, 1'b0, 9'h100};
    vecs[1]  = '{"sub_05_03",   3'b101, 8'h05, 8'h03, 1'b1, 9'h002};
    vecs[2]  = '{"sub_03_05",   3'b101, 8'h03, 8'h05, 1'b1, 9'h1FE};
    vecs[3]  = '{"rsv_110",     3'b110, 8'hFF, 8'hFF, 1'b0, 9'h000};
    vecs[4]  = '{"and_f0_3c",   3'b000, 8'hF0, 8'h3C, 1'b0, 9'h030};
    vecs[5]  = '{"nor_f0_0c",   3'b011, 8'hF0, 8'h0C, 1'b0, 9'h003};
    vecs[6]  = '{"or_12_81",    3'b001, 8'h12, 8'h81, 1'b1, 9'h093};
    vecs[7]  = '{"xor_a5_ff",   3'b010, 8'hA5, 8'hFF, 1'b0, 9'h05A};
    vecs[8]  = '{"add_7f_80_c", 3'b100, 8'h7F, 8'h80, 1'b1, 9'h100};
    vecs[9]  = '{"add_12_34_c", 3'b100, 8'h12, 8'h34, 1'b1, 9'h047};
    vecs[10] = '{"sub_00_01_n", 3'b101, 8'h00, 8'h01, 1'b0, 9'h1FE};
    vecs[11] = '{"rsv_111",     3'b111, 8'hAA, 8'h55, 1'b1, 9'h000};
    vecs[12] = '{"sub_ff_ff",   3'b101, 8'hFF, 8'hFF, 1'b1, 9'h000};

    // Reset with start asserted: start must be ignored.
    rst_n = 1'b0; start = 1'b1; a = 8'h11; b = 8'h22; c_in = 1'b1; ALOP = 3'b100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // start pulsed mid-RUN with different operands is ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h20; c_in = 1'b0; ALOP = 3'b100; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0; r1 = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        a = 8'hFF; b = 8'hFF; c_in = 1'b1; ALOP = 3'b010; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        r1 = result;
      end
    end
    check("midrun done_pulses", 32'(done_cnt), 32'd1);
    check("midrun result", 32'(r1), 32'h030);

    // Back-to-back: start held in the DONE cycle.
    @(negedge clk);
    a = 8'hF0; b = 8'h3C; c_in = 1'b0; ALOP = 3'b000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (t1 < 0) begin
          t1 = cyc; r1 = result;
          if (busy) check("b2b busy_in_done", 32'(busy), 32'd0);
          a = 8'h0F; b = 8'hFF; c_in = 1'b0; ALOP = 3'b010; start = 1'b1;
        end else begin
          t2 = cyc; r2 = result;
        end
      end
    end
    check("b2b done_pulses", 32'(done_cnt), 32'd2);
    check("b2b first_latency", 32'(t1), 32'd8);
    check("b2b gap", 32'(t2 - t1), 32'd9);
    check("b2b first_result", 32'(r1), 32'h030);
    check("b2b second_result", 32'(r2), 32'h0F0);

    // Reset during RUN aborts the operation.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; c_in = 1'b0; ALOP = 3'b100; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(result), 32'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("abort no_activity", 32'(done_cnt), 32'd0);

    // Carry register must come out of reset cleared and work again.
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
